// File: rtl/bullet_pkg.sv
// Shared constants and types for the bullet sprite RAM arbiter.
package bullet_pkg;

  localparam int NUM_REQ    = 4;
  localparam int SPR_W      = 25;
  localparam int SPR_H      = 7;
  localparam int RAM_ADDR_W = 19;
  localparam int PIX_W      = 5;
  localparam int X_W        = 5;
  localparam int Y_W        = 3;
  localparam int ID_W       = $clog2(NUM_REQ);

  localparam logic [PIX_W-1:0] TRANSPARENT = '0;

  typedef logic [ID_W-1:0] req_id_t;

  // One pipeline stage of an in-flight fetch.
  typedef struct packed {
    logic    valid;
    req_id_t id;
    logic    oor;
  } fetch_stage_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first eligible requester at or after ptr_i, wrapping.
module rr_arbiter
  import bullet_pkg::*;
#(
  parameter int N = NUM_REQ
) (
  input  logic [N-1:0] req_i,
  input  logic [N-1:0] mask_i,
  input  req_id_t      ptr_i,
  output logic [N-1:0] gnt_o,
  output req_id_t      idx_o,
  output logic         valid_o
);

  logic [N-1:0] eligible;
  req_id_t      cand;
  logic         found;

  assign eligible = req_i & ~mask_i;

  // NOTE: every output and temporary gets a default before the loop so no latch is inferred.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < N; k++) begin
      cand = req_id_t'((int'(ptr_i) + k) % N);
      if (!found && eligible[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
    valid_o = found;
  end

endmodule

// File: rtl/bullet_sprite_arb.sv
// Arbitrates pixel fetches from several bullet requesters onto one sprite RAM
// read port; grant/address at T+1, pixel response at T+2, in grant order.
module bullet_sprite_arb #(
  parameter int NUM_REQ = bullet_pkg::NUM_REQ,
  parameter int SPR_W   = bullet_pkg::SPR_W,
  parameter int SPR_H   = bullet_pkg::SPR_H
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic [NUM_REQ-1:0]                        req_i,
  input  logic [NUM_REQ-1:0][bullet_pkg::X_W-1:0]   req_x_i,
  input  logic [NUM_REQ-1:0][bullet_pkg::Y_W-1:0]   req_y_i,
  output logic [NUM_REQ-1:0]                        gnt_o,
  output logic [bullet_pkg::RAM_ADDR_W-1:0]         ram_addr_o,
  input  logic [bullet_pkg::PIX_W-1:0]              ram_rdata_i,
  output logic                                      rsp_valid_o,
  output bullet_pkg::req_id_t                       rsp_id_o,
  output logic [bullet_pkg::PIX_W-1:0]              rsp_pixel_o
);

  import bullet_pkg::*;

  logic [NUM_REQ-1:0]    gnt_q, gnt_d;
  req_id_t               rr_ptr_q, rr_ptr_d;
  req_id_t               arb_idx;
  logic                  arb_valid;
  logic [RAM_ADDR_W-1:0] ram_addr_q, ram_addr_d;
  fetch_stage_t          gnt_stage_q, gnt_stage_d;
  fetch_stage_t          rsp_stage_q;

  logic [X_W-1:0]        sel_x;
  logic [Y_W-1:0]        sel_y;
  logic                  in_range;

  // The grant currently on gnt_o masks its owner while it drops req.
  rr_arbiter #(.N(NUM_REQ)) u_rr_arbiter (
    .req_i   (req_i),
    .mask_i  (gnt_q),
    .ptr_i   (rr_ptr_q),
    .gnt_o   (gnt_d),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  assign sel_x    = req_x_i[arb_idx];
  assign sel_y    = req_y_i[arb_idx];
  assign in_range = (int'(sel_x) < SPR_W) && (int'(sel_y) < SPR_H);

  always_comb begin
    rr_ptr_d          = rr_ptr_q;
    ram_addr_d        = ram_addr_q;
    gnt_stage_d       = '0;
    gnt_stage_d.valid = arb_valid;
    gnt_stage_d.id    = arb_idx;
    gnt_stage_d.oor   = arb_valid && !in_range;
    if (arb_valid) begin
      rr_ptr_d = req_id_t'((int'(arb_idx) + 1) % NUM_REQ);
      // Out-of-range fetches leave the address alone; their pixel is forced later.
      if (in_range) begin
        ram_addr_d = RAM_ADDR_W'(sel_y) * RAM_ADDR_W'(SPR_W) + RAM_ADDR_W'(sel_x);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_q       <= '0;
      rr_ptr_q    <= '0;
      ram_addr_q  <= '0;
      gnt_stage_q <= '0;
      rsp_stage_q <= '0;
    end else begin
      gnt_q       <= gnt_d;
      rr_ptr_q    <= rr_ptr_d;
      ram_addr_q  <= ram_addr_d;
      gnt_stage_q <= gnt_stage_d;
      rsp_stage_q <= gnt_stage_q;
    end
  end

  // RAM data arrives in the response cycle, so the pixel is selected combinationally.
  assign gnt_o       = gnt_q;
  assign ram_addr_o  = ram_addr_q;
  assign rsp_valid_o = rsp_stage_q.valid;
  assign rsp_id_o    = rsp_stage_q.id;
  assign rsp_pixel_o = (rsp_stage_q.valid && !rsp_stage_q.oor) ? ram_rdata_i : TRANSPARENT;

endmodule

// File: tb/tb_bullet_sprite_arb.sv
// Randomized self-checking bench for bullet_sprite_arb against a queue-based model.
module tb_bullet_sprite_arb;

  localparam int N = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic [N-1:0]     req = '0;
  logic [N-1:0][4:0] rx = '0;
  logic [N-1:0][2:0] ry = '0;
  logic [N-1:0]     gnt;
  logic [18:0]      addr;
  logic [4:0]       rdata = '0;
  logic             rv;
  logic [1:0]       rid;
  logic [4:0]       rpix;

  always #5 clk = ~clk;

  // Sprite RAM: one-cycle registered read, mem[a] = a mod 8.
  always @(posedge clk) rdata <= 5'(addr % 19'd8);

  bullet_sprite_arb dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_i       (req),
    .req_x_i     (rx),
    .req_y_i     (ry),
    .gnt_o       (gnt),
    .ram_addr_o  (addr),
    .ram_rdata_i (rdata),
    .rsp_valid_o (rv),
    .rsp_id_o    (rid),
    .rsp_pixel_o (rpix)
  );

  typedef struct {
    int due;
    int id;
    int pix;
  } rsp_t;

  int           n_vec = 0;
  int           n_err = 0;
  int           cyc = 0;
  int           ptr = 0;
  int           m_addr = 0;
  logic [N-1:0] m_gnt = '0;
  logic [N-1:0] vis_last = '0;
  rsp_t         exp_q[$];

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Apply the arbitration rules to the inputs driven this cycle.
  task automatic predict();
    logic [N-1:0] nxt;
    bit           found;
    int           pix;
    nxt   = '0;
    found = 0;
    for (int k = 0; k < N; k++) begin
      int i;
      i = (ptr + k) % N;
      if (!found && req[i] && !m_gnt[i]) begin
        found  = 1;
        nxt[i] = 1'b1;
        ptr    = (i + 1) % N;
        if (int'(rx[i]) < 25 && int'(ry[i]) < 7) begin
          m_addr = int'(ry[i]) * 25 + int'(rx[i]);
          pix    = m_addr % 8;
        end else begin
          pix = 0;
        end
        exp_q.push_back('{cyc + 2, i, pix});
      end
    end
    m_gnt = nxt;
  endtask

  // Called at a falling edge with inputs already driven; returns at the next falling edge.
  task automatic step();
    rsp_t r;
    predict();
    @(posedge clk);
    cyc++;
    #1;
    check("gnt", gnt, m_gnt);
    check("ram_addr", addr, m_addr);
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      r = exp_q.pop_front();
      check("rsp_valid", rv, 1);
      check("rsp_id", rid, r.id);
      check("rsp_pixel", rpix, r.pix);
    end else begin
      check("rsp_valid_idle", rv, 0);
    end
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    check("rst_gnt", gnt, 0);
    check("rst_rsp_valid", rv, 0);
    check("rst_ram_addr", addr, 0);
    check("rst_rsp_pixel", rpix, 0);
    ptr      = 0;
    m_gnt    = '0;
    m_addr   = 0;
    vis_last = '0;
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic new_xy(input int i);
    rx[i] = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(25, 31)) : 5'($urandom_range(0, 24));
    ry[i] = 3'($urandom_range(0, 7));
  endtask

  initial begin
    @(negedge clk);
    apply_reset();

    // Idle: no grant, no response.
    step();
    step();

    // Single request, in range.
    req = 4'b0100; rx[2] = 5'd3; ry[2] = 3'd1;
    step();
    check("t031_gnt", gnt, 4'b0100);
    check("t031_addr", addr, 28);
    step();
    check("t031_pixel", rpix, 4);
    req = '0;
    step();

    // Out-of-range column: granted, address held, transparent pixel.
    req = 4'b0010; rx[1] = 5'd25; ry[1] = 3'd0;
    step();
    check("t033_gnt", gnt, 4'b0010);
    check("t033_addr_hold", addr, 28);
    step();
    check("t033_pixel", rpix, 0);
    check("t033_id", rid, 1);
    req = '0;
    step();

    // Last sprite entry.
    req = 4'b1000; rx[3] = 5'd24; ry[3] = 3'd6;
    step();
    check("t034_addr", addr, 174);
    step();
    check("t034_pixel", rpix, 6);
    req = '0;
    step();

    // All requesting continuously after reset.
    apply_reset();
    for (int i = 0; i < N; i++) begin
      rx[i] = 5'(i * 5 + 1);
      ry[i] = 3'(i);
    end
    req = '1;
    for (int k = 0; k < 12; k++) begin
      step();
      check("t032_order", gnt, 1 << (k % N));
    end

    // Reset while a grant is visible; arbitration restarts at requester 0.
    step();
    check("t035_pre_gnt", gnt, 4'b0001);
    apply_reset();
    step();
    check("t035_first_gnt", gnt, 4'b0001);
    step();
    step();

    // Randomized traffic with requesters following the req/gnt handshake.
    req = '0;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 499) == 0) apply_reset();
      for (int i = 0; i < N; i++) begin
        if (req[i]) begin
          if (vis_last[i]) begin
            if ($urandom_range(0, 1) == 0) req[i] = 1'b0;
            else new_xy(i);
          end
        end else if ($urandom_range(0, 2) == 0) begin
          req[i] = 1'b1;
          new_xy(i);
        end
      end
      vis_last = m_gnt;
      step();
    end

    req = '0;
    step();
    step();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bullet_sprite_arb.md
BULLET_SPRITE_ARB -- requirements
Module: bullet_sprite_arb

Interface
REQ-001 Parameter NUM_REQ, default 4, number of bullet pixel requesters sharing the single bullet sprite RAM read port.
REQ-002 Parameter SPR_W, default 25, sprite width in pixels.
REQ-003 Parameter SPR_H, default 7, sprite height in pixels; SPR_W*SPR_H = 175 RAM entries.
REQ-004 Clk  input  1  single clock; all state updates on its rising edge.
REQ-005 Reset_n  input  1  reset, asynchronous assert, active-low.
REQ-006 req  input  NUM_REQ  per-requester pixel fetch request, level, held until granted.
REQ-007 req_x  input  NUM_REQ x 5  per-requester sprite column, stable while req high.
REQ-008 req_y  input  NUM_REQ x 3  per-requester sprite row, stable while req high.
REQ-009 gnt  output  NUM_REQ  one-hot grant, one-cycle pulse.
REQ-010 ram_addr  output  19  read address to sprite RAM (RAM has 1-cycle registered read).
REQ-011 ram_rdata  input  5  read data from sprite RAM.
REQ-012 rsp_valid  output  1  response pixel valid, one-cycle pulse.
REQ-013 rsp_id  output  2  index of the requester owning the response.
REQ-014 rsp_pixel  output  5  returned palette index; 0 = transparent.

Function
REQ-015 Round-robin arbitration: in cycle T, among req bits not masked by REQ-017, grant the first index at or after rr_ptr (wrapping); gnt, ram_addr registered, visible in T+1.
REQ-016 After each grant to index i, rr_ptr = (i+1) mod NUM_REQ; with no grant rr_ptr holds.
REQ-017 A requester whose gnt is high in the current cycle is excluded from arbitration in that cycle (no double grant while it drops req).
REQ-018 Requester drops req in the cycle after seeing gnt, or keeps it high with new x/y for a new fetch.
REQ-019 ram_addr = req_y*SPR_W + req_x of the granted requester, zero-extended to 19 bits; no truncation for in-range coordinates (max 174).
REQ-020 Out-of-range request (req_x >= SPR_W or req_y >= SPR_H): still granted, ram_addr holds previous value, response forced to rsp_pixel = 0.
REQ-021 Latency: grant seen in T+1, rsp_valid/rsp_id/rsp_pixel in T+2; rsp_pixel = ram_rdata unless out-of-range flag pipelined with it.
REQ-022 Throughput: one grant per cycle when any eligible request exists; responses return in grant order, no reordering.
REQ-023 No request: gnt = 0, rsp_valid two cycles later = 0, ram_addr holds.
REQ-024 All requests simultaneous: each of NUM_REQ requesters granted exactly once within NUM_REQ consecutive grant cycles.

Reset
REQ-025 Reset_n low asynchronously clears gnt, rsp_valid, rsp_id, rsp_pixel, ram_addr to 0 and rr_ptr to 0 (requester 0 highest priority).
REQ-026 Reset mid-operation drops all in-flight grants/responses; no rsp_valid for them after release.
REQ-027 First grant possible in cycle after Reset_n deasserts; first response two cycles later.

Structure
REQ-028 Shared package bullet_pkg holds NUM_REQ, SPR_W, SPR_H, RAM_ADDR_W (19), PIX_W (5), TRANSPARENT (0) and requester-id type.
REQ-029 Sub-module rr_arbiter (req vector, mask, rr_ptr -> one-hot grant, index) is instantiated once; address calc and response pipeline stay in top.

Verification
REQ-030 Bench models sprite RAM with 1-cycle registered read, mem[a] = a mod 8.
REQ-031 Single req[2], x=3, y=1 -> gnt=0100 at T+1, ram_addr=28, rsp_valid at T+2, rsp_id=2, rsp_pixel=4.
REQ-032 req=1111 held continuously after reset -> grant order 0,1,2,3,0,... one per cycle, rsp_id sequence identical, 2-cycle offset.
REQ-033 req[1] with x=25, y=0 -> gnt[1] pulses, ram_addr unchanged, rsp_pixel=0, rsp_id=1.
REQ-034 Boundary x=24, y=6 -> ram_addr=174, rsp_pixel=6.
REQ-035 Reset_n pulsed low during T+1 of a grant -> gnt, rsp_valid 0 immediately, no response after release, next grant starts from requester 0.
